// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among result sources, one registered broadcast per cycle.
// Build option: define CDB_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority instead of round-robin.

module cdb_arb_lane #(
  parameter int TAG_W = 4
) (
  input  logic             req,
  input  logic [TAG_W-1:0] tag,
  output logic             elig
);
  // tag 0 means "no result"; such a request is ignored entirely
  assign elig = req && (tag != '0);
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [TAG_W-1:0]          cdb_id,
  output logic [DATA_W-1:0]         cdb_data,
  output logic                      cdb_valid,
  output logic [CNT_W-1:0]          conflict_cnt
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   idx;
  logic               multi;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    cdb_arb_lane #(.TAG_W(TAG_W)) u_lane (
      .req  (req[i]),
      .tag  (req_tag[i*TAG_W +: TAG_W]),
      .elig (elig[i])
    );
  end

  // two or more eligible bits <=> clearing the lowest set bit leaves something
  assign multi = |(elig & (elig - 1'b1));

`ifdef CDB_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W:0]   sum;

  // scan rr_ptr, rr_ptr+1, ... with wrap; the extra sum bit absorbs the overflow
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (found)
      rr_ptr <= (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
  end
`endif

  always_comb begin
    grant = '0;
    if (found && !rst) grant = NUM_REQ'(1) << gidx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_id       <= '0;
      cdb_data     <= '0;
      cdb_valid    <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (found) begin
        cdb_id    <= req_tag[gidx*TAG_W +: TAG_W];
        cdb_data  <= req_data[gidx*DATA_W +: DATA_W];
        cdb_valid <= 1'b1;
      end else begin
        cdb_id    <= '0;
        cdb_data  <= '0;
        cdb_valid <= 1'b0;
      end
      if (multi && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single request, full round-robin, notag, reset mid-flight, two-source mode.
module tb_cdb_arbiter;
  localparam int NUM_REQ = 8;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [TAG_W-1:0]          cdb_id;
  logic [DATA_W-1:0]         cdb_data;
  logic                      cdb_valid;
  logic [CNT_W-1:0]          conflict_cnt;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .grant        (grant),
    .cdb_id       (cdb_id),
    .cdb_data     (cdb_data),
    .cdb_valid    (cdb_valid),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int i, input logic r, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    req[i]                       = r;
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NUM_REQ-1:0] eg;
    logic [TAG_W-1:0]   et;
    rst = 1'b1; req = '0; req_tag = '0; req_data = '0;
    tick(); tick();
    chk("rst_grant", grant, 0);
    rst = 1'b0;
    chk("rst_valid", cdb_valid, 0);
    chk("rst_id", cdb_id, 0);
    chk("rst_data", cdb_data, 0);
    chk("rst_cnt", conflict_cnt, 0);
    tick();
    chk("idle_valid", cdb_valid, 0);

    // single request on source 4
    set_src(4, 1'b1, 4'd5, 64'h0000_0000_DEAD_BEEF);
    #1 chk("single_grant", grant, 8'b0001_0000);
    tick();
    set_src(4, 1'b0, 4'd0, 64'h0);
    chk("single_id", cdb_id, 5);
    chk("single_data", cdb_data, 64'h0000_0000_DEAD_BEEF);
    chk("single_valid", cdb_valid, 1);
    tick();
    chk("single_after_valid", cdb_valid, 0);
    chk("single_after_id", cdb_id, 0);
    chk("single_after_data", cdb_data, 0);

    // tag-0 request is invisible (pointer now at 5; search wraps to 2,3)
    set_src(2, 1'b1, 4'd0, 64'h22);
    set_src(3, 1'b1, 4'd3, 64'h33);
    #1 chk("notag_grant", grant, 8'b0000_1000);
    tick();
    set_src(2, 1'b0, 4'd0, 64'h0);
    set_src(3, 1'b0, 4'd0, 64'h0);
    chk("notag_id", cdb_id, 3);
    chk("notag_data", cdb_data, 64'h33);
    chk("notag_cnt", conflict_cnt, 0);
    tick();

    // all sources continuously from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_cnt0", conflict_cnt, 0);
    for (int i = 0; i < NUM_REQ; i++) set_src(i, 1'b1, TAG_W'(i+1), 64'h100 + 64'(i));
    for (int c = 0; c < 9; c++) begin
      #1 chk($sformatf("rr_grant%0d", c), grant, 64'(8'(1) << (c % 8)));
      tick();
      chk($sformatf("rr_id%0d", c), cdb_id, 64'((c % 8) + 1));
      chk($sformatf("rr_data%0d", c), cdb_data, 64'h100 + 64'(c % 8));
      chk($sformatf("rr_cnt%0d", c), conflict_cnt, 64'(c + 1));
    end
    req = '0; req_tag = '0; req_data = '0;
    tick();

    // reset in a cycle with req[1] pending
    set_src(1, 1'b1, 4'd2, 64'hABCD);
    rst = 1'b1;
    #1 chk("midrst_grant", grant, 0);
    tick();
    chk("midrst_valid", cdb_valid, 0);
    chk("midrst_id", cdb_id, 0);
    chk("midrst_cnt", conflict_cnt, 0);
    rst = 1'b0;
    #1 chk("postrst_grant", grant, 8'b0000_0010);
    tick();
    set_src(1, 1'b0, 4'd0, 64'h0);
    chk("postrst_id", cdb_id, 2);
    chk("postrst_data", cdb_data, 64'hABCD);
    chk("postrst_valid", cdb_valid, 1);

    // reset must return the pointer to 0 (it sits at 2 now)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_src(0, 1'b1, 4'd1, 64'hA0);
    set_src(5, 1'b1, 4'd6, 64'hA5);
    for (int c = 0; c < 4; c++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
      eg = 8'b0000_0001; et = 4'd1;
`else
      eg = (c % 2 == 0) ? 8'b0000_0001 : 8'b0010_0000;
      et = (c % 2 == 0) ? 4'd1 : 4'd6;
`endif
      #1 chk($sformatf("two_grant%0d", c), grant, eg);
      tick();
      chk($sformatf("two_id%0d", c), cdb_id, et);
      chk($sformatf("two_cnt%0d", c), conflict_cnt, 64'(c + 1));
    end
    req = '0;
    tick();
    chk("end_valid", cdb_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) between functional-unit reservation stations (add_1..3, mult_1..2, ld_1..3) that hold completed results.
- Each cycle, at most one requester is granted using round-robin.
- The granted requester's tag/data are registered onto cdb_id/cdb_data for one cycle. The register file and reservation stations consume them there.
- Store stations (tags 9, 10) produce no result and never request.

Parameters:
NUM_REQ, 8, number of requesting result sources (index 0..NUM_REQ-1).
TAG_W, 4, width of a reservation-station tag; tag 0 = notag.
DATA_W, 64, result data width.
CNT_W, 16, width of the saturating conflict counter.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
req  input  NUM_REQ  per-source request; held high until granted.
req_tag  input  NUM_REQ*TAG_W  flattened tags; source i at [i*TAG_W +: TAG_W].
req_data  input  NUM_REQ*DATA_W  flattened results; source i at [i*DATA_W +: DATA_W].
grant  output  NUM_REQ  one-hot (or zero) combinational grant for the current cycle.
cdb_id  output  TAG_W  registered broadcast tag; 0 when idle.
cdb_data  output  DATA_W  registered broadcast data; 0 when idle.
cdb_valid  output  1  registered; 1 when cdb_id/cdb_data carry a result.
conflict_cnt  output  CNT_W  saturating count of cycles with more than one eligible request.

Behaviour:
- Eligible(i) = req[i] && req_tag[i] != 0. A request with tag 0 is never granted and never counted.
- rr_ptr: internal register, range 0..NUM_REQ-1, reset 0.
- Grant selection (combinational): the first eligible index, searching from rr_ptr upward with wrap to 0. At most one bit of grant is set. grant = 0 when no source is eligible or rst = 1.
- Posedge, rst = 1: cdb_id = 0, cdb_data = 0, cdb_valid = 0, rr_ptr = 0, conflict_cnt = 0.
- Posedge, rst = 0, grant to source g:
  - cdb_id <= req_tag[g], cdb_data <= req_data[g], cdb_valid <= 1.
  - rr_ptr <= (g == NUM_REQ-1) ? 0 : g+1.
- Posedge, rst = 0, no grant: cdb_id <= 0, cdb_data <= 0, cdb_valid <= 0. rr_ptr holds.
- Latency: a result granted in cycle N is on the CDB for exactly cycle N+1. Back-to-back grants give a continuous broadcast, one result per cycle.
- Handshake: a requester samples grant[i] at the posedge. If it was granted, it deasserts req (or presents its next result) in the following cycle. An ungranted requester must hold req_tag/req_data stable. The arbiter does not buffer unaccepted data.
- Fairness: with all NUM_REQ sources requesting continuously, each is granted exactly once per NUM_REQ cycles.
- conflict_cnt: +1 on each non-reset posedge where the eligible count ≥ 2. It saturates at all-ones and never wraps.
- Reset mid-operation: a grant asserted in the same cycle as rst is void (grant is forced 0). Any in-flight CDB word is cleared to notag on the reset edge.
- Duplicate tags from two sources are not checked. Each is broadcast in its own granted cycle.

Optional Feature:
CDB_ARB_FIXED_PRIO_EN
- Defined: fixed priority replaces round-robin. The lowest eligible index always wins. rr_ptr is not implemented, or is held at 0.
- Not defined: round-robin as specified above.
- Latency, handshake, reset and conflict_cnt are identical in both modes.

Test Plan:
1. Reset, then idle, all req = 0 -> cdb_valid = 0, cdb_id = 0, cdb_data = 0, conflict_cnt = 0.
2. Single request, req[4] = 1, tag 5, data 64'h0000_0000_DEAD_BEEF in cycle N -> grant = 8'b0001_0000 in N. Cycle N+1: cdb_id = 5, data = DEAD_BEEF, valid = 1. Cycle N+2: valid = 0, cdb_id = 0.
3. All 8 sources request continuously (tags 1..8) from reset -> grants in order 0,1,...,7,0. Each tag appears once in 8 consecutive CDB cycles. conflict_cnt increments every cycle.
4. req[2] = 1 with tag 0 and req[3] = 1 with tag 3 -> only source 3 granted. cdb_id = 3 next cycle. conflict_cnt unchanged.
5. rst asserted in a cycle where req[1] = 1 -> grant = 0 that cycle. After reset, cdb_valid = 0 and rr_ptr = 0; releasing rst with req[1] still high grants source 1.
6. With CDB_ARB_FIXED_PRIO_EN defined, req[0] and req[5] held high -> source 0 granted every cycle and source 5 never granted. Without the macro, sources 0 and 5 alternate.
